// File: rtl/machine_ctrl.sv
// -----------------------------------------------------------------------------
// machine_ctrl: instruction-cycle control sequencer for the RISC CPU.
//
// Decodes the clock generator's 8-phase one-hot phase bus together with the
// latched opcode/zero flag into registered control strobes for the PC,
// instruction register, accumulator, memory and data bus. The strobes that
// belong to the phase sampled at one edge are driven for the following cycle.
//
// Parameters:
//   OP_W         opcode width (encoding fixed: HLT=0 SKZ=1 ADD=2 ANDD=3
//                XORR=4 LDA=5 STO=6 JMP=7)
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   state        one-hot phase S1..S8 (bit0=S1), 8'h00 = IDLE
//   fetch        high during S1..S4
//   alu_en       high during S7
//   opcode       instruction register opcode field
//   zero         accumulator-zero flag
//   inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena
//                registered control strobes
//   halt         sticky halt indication
//   phase_err    sticky phase-protocol error
//
// Optional feature: define MACHINE_CTRL_PHASE_CHECK_EN to build the phase
// protocol checker that drives phase_err; otherwise phase_err is tied 0.
// -----------------------------------------------------------------------------
module machine_ctrl #(
    parameter int unsigned OP_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      state,
    input  logic            fetch,
    input  logic            alu_en,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            load_ir,
    output logic            rd,
    output logic            wr,
    output logic            datactl_ena,
    output logic            halt,
    output logic            phase_err
);

    localparam logic [7:0] PhIdle = 8'h00;
    localparam logic [7:0] PhS1   = 8'h01;
    localparam logic [7:0] PhS2   = 8'h02;
    localparam logic [7:0] PhS3   = 8'h04;
    localparam logic [7:0] PhS4   = 8'h08;
    localparam logic [7:0] PhS5   = 8'h10;
    localparam logic [7:0] PhS6   = 8'h20;
    localparam logic [7:0] PhS7   = 8'h40;
    localparam logic [7:0] PhS8   = 8'h80;

    localparam logic [OP_W-1:0] OpHlt  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSkz  = OP_W'(1);
    localparam logic [OP_W-1:0] OpAdd  = OP_W'(2);
    localparam logic [OP_W-1:0] OpAndd = OP_W'(3);
    localparam logic [OP_W-1:0] OpXorr = OP_W'(4);
    localparam logic [OP_W-1:0] OpLda  = OP_W'(5);
    localparam logic [OP_W-1:0] OpSto  = OP_W'(6);
    localparam logic [OP_W-1:0] OpJmp  = OP_W'(7);

    logic [OP_W-1:0] op_q, op_d;
    logic            zero_q, zero_d;
    logic            halt_d;
    logic            inc_pc_d, load_pc_d, load_acc_d, load_ir_d;
    logic            rd_d, wr_d, datactl_ena_d;
    logic            alu_class;

    // Execute-half decisions only ever look at the opcode latched at S3.
    assign alu_class = (op_q == OpAdd) || (op_q == OpAndd) ||
                       (op_q == OpXorr) || (op_q == OpLda);

    always_comb begin
        inc_pc_d      = 1'b0;
        load_pc_d     = 1'b0;
        load_acc_d    = 1'b0;
        load_ir_d     = 1'b0;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        datactl_ena_d = 1'b0;
        halt_d        = halt;
        op_d          = op_q;
        zero_d        = zero_q;

        // Once halted every strobe stays low and op_q/zero_q are frozen.
        if (!halt) begin
            unique case (state)
                PhS1: begin
                    if (fetch) begin
                        rd_d      = 1'b1;
                        load_ir_d = 1'b1;
                    end
                end
                PhS2: begin
                    if (fetch) begin
                        rd_d      = 1'b1;
                        load_ir_d = 1'b1;
                        inc_pc_d  = 1'b1;
                    end
                end
                PhS3: begin
                    op_d   = opcode;
                    zero_d = zero;
                end
                PhS4: begin
                    if (op_q == OpHlt) begin
                        halt_d = 1'b1;
                    end else begin
                        inc_pc_d = 1'b1;
                    end
                end
                PhS5: begin
                    rd_d          = alu_class;
                    load_pc_d     = (op_q == OpJmp);
                    datactl_ena_d = (op_q == OpSto);
                end
                PhS6: begin
                    rd_d          = alu_class;
                    load_pc_d     = (op_q == OpJmp);
                    inc_pc_d      = (op_q == OpJmp) || ((op_q == OpSkz) && zero_q);
                    wr_d          = (op_q == OpSto);
                    datactl_ena_d = (op_q == OpSto);
                end
                PhS7: begin
                    rd_d          = alu_class;
                    load_acc_d    = alu_class && alu_en;
                    datactl_ena_d = (op_q == OpSto);
                end
                PhS8: begin
                    inc_pc_d = (op_q == OpSkz) && zero_q;
                end
                default: begin
                    // IDLE or a malformed phase: nothing asserted.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            load_acc    <= 1'b0;
            load_ir     <= 1'b0;
            rd          <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
            halt        <= 1'b0;
            op_q        <= OpHlt;
            zero_q      <= 1'b0;
        end else begin
            inc_pc      <= inc_pc_d;
            load_pc     <= load_pc_d;
            load_acc    <= load_acc_d;
            load_ir     <= load_ir_d;
            rd          <= rd_d;
            wr          <= wr_d;
            datactl_ena <= datactl_ena_d;
            halt        <= halt_d;
            op_q        <= op_d;
            zero_q      <= zero_d;
        end
    end

`ifdef MACHINE_CTRL_PHASE_CHECK_EN
    logic [7:0] prev_q;
    logic [7:0] succ;
    logic       onehot0;
    logic       seq_ok;
    logic       fetch_chk;
    logic       phase_err_d;

    always_comb begin
        onehot0 = ((state & (state - 8'd1)) == 8'd0);
        // The phase ring rotates S8 back to S1; IDLE leads only to S1.
        succ    = (prev_q == PhIdle) ? PhS1 : {prev_q[6:0], prev_q[7]};
        // The generator may sit in IDLE, but only while it is already idle.
        seq_ok  = (state == succ) || ((state == PhIdle) && (prev_q == PhIdle));
        // fetch is unchecked in IDLE and on the first S1 leaving IDLE.
        fetch_chk = (state != PhIdle) && !((state == PhS1) && (prev_q == PhIdle));
        phase_err_d = phase_err || !onehot0 || !seq_ok ||
                      (fetch_chk && (fetch != (|state[3:0]))) ||
                      (alu_en && (state != PhS7));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q    <= PhIdle;
            phase_err <= 1'b0;
        end else begin
            prev_q    <= state;
            phase_err <= phase_err_d;
        end
    end
`else
    assign phase_err = 1'b0;
`endif

endmodule

// File: tb/tb_machine_ctrl.sv
module tb_machine_ctrl;

    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] S1 = 8'h01, S2 = 8'h02, S3 = 8'h04, S4 = 8'h08;
    localparam logic [7:0] S5 = 8'h10, S6 = 8'h20, S7 = 8'h40, S8 = 8'h80;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6, JMP = 3'd7;

    // Expected-output byte: {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}
    localparam logic [7:0] HALT = 8'h80, INC = 8'h40, LDPC = 8'h20, LDACC = 8'h10;
    localparam logic [7:0] LDIR = 8'h08, RD = 8'h04, WR = 8'h02, DCTL = 8'h01;

`ifdef MACHINE_CTRL_PHASE_CHECK_EN
    localparam logic PC_EN = 1'b1;
`else
    localparam logic PC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] state = 8'h00;
    logic       fetch = 1'b0;
    logic       alu_en = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, phase_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst_n;
        logic [7:0] state;
        logic       fetch;
        logic       alu_en;
        logic [2:0] opcode;
        logic       zero;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    machine_ctrl #(.OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .fetch(fetch), .alu_en(alu_en),
        .opcode(opcode), .zero(zero), .inc_pc(inc_pc), .load_pc(load_pc),
        .load_acc(load_acc), .load_ir(load_ir), .rd(rd), .wr(wr),
        .datactl_ena(datactl_ena), .halt(halt), .phase_err(phase_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};
    endfunction

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got outs=%b perr=%b, expected outs=%b perr=%b",
                     name, got[8:1], got[0], exp[8:1], exp[0]);
        end
    endtask

    task automatic add_v(input logic r, input logic [7:0] st, input logic f,
                         input logic [2:0] op, input logic z, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.state = st; v.fetch = f; v.alu_en = (st == S7);
        v.opcode = op; v.zero = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add(input logic r, input logic [7:0] st, input logic [2:0] op,
                       input logic z, input logic [7:0] e);
        add_v(r, st, |st[3:0], op, z, e);
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [7:0] st, input logic f, input logic a,
                        input logic [2:0] op);
        @(negedge clk);
        rst_n = r; state = st; fetch = f; alu_en = a; opcode = op; zero = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then an LDA whose first S1 arrives with fetch low (gated).
        add(0, IDLE, HLT, 0, 0);
        add(0, IDLE, HLT, 0, 0);
        add(1, IDLE, LDA, 0, 0);
        add_v(1, S1, 1'b0, LDA, 0, 0);
        add(1, S2, LDA, 0, RD | LDIR | INC);
        add(1, S3, LDA, 0, 0);
        add(1, S4, LDA, 0, INC);
        add(1, S5, LDA, 0, RD);
        add(1, S6, LDA, 0, RD);
        add(1, S7, LDA, 0, RD | LDACC);
        add(1, S8, LDA, 0, 0);
        // ADD, zero=0
        add(1, S1, ADD, 0, RD | LDIR);
        add(1, S2, ADD, 0, RD | LDIR | INC);
        add(1, S3, ADD, 0, 0);
        add(1, S4, ADD, 0, INC);
        add(1, S5, ADD, 0, RD);
        add(1, S6, ADD, 0, RD);
        add(1, S7, ADD, 0, RD | LDACC);
        add(1, S8, ADD, 0, 0);
        // STO captured at S3; live opcode switches to ADD from S4 onward.
        add(1, S1, STO, 0, RD | LDIR);
        add(1, S2, STO, 0, RD | LDIR | INC);
        add(1, S3, STO, 0, 0);
        add(1, S4, ADD, 0, INC);
        add(1, S5, ADD, 0, DCTL);
        add(1, S6, ADD, 0, WR | DCTL);
        add(1, S7, ADD, 0, DCTL);
        add(1, S8, ADD, 0, 0);
        // SKZ with zero=1 only at S3: two extra increments from zero_q.
        add(1, S1, SKZ, 0, RD | LDIR);
        add(1, S2, SKZ, 0, RD | LDIR | INC);
        add(1, S3, SKZ, 1, 0);
        add(1, S4, SKZ, 0, INC);
        add(1, S5, SKZ, 0, 0);
        add(1, S6, SKZ, 0, INC);
        add(1, S7, SKZ, 0, 0);
        add(1, S8, SKZ, 0, INC);
        // SKZ with zero=0: no extra increments.
        add(1, S1, SKZ, 1, RD | LDIR);
        add(1, S2, SKZ, 1, RD | LDIR | INC);
        add(1, S3, SKZ, 0, 0);
        add(1, S4, SKZ, 1, INC);
        add(1, S5, SKZ, 1, 0);
        add(1, S6, SKZ, 1, 0);
        add(1, S7, SKZ, 1, 0);
        add(1, S8, SKZ, 1, 0);
        // JMP interrupted by reset at S6, then a full JMP.
        add(1, S1, JMP, 0, RD | LDIR);
        add(1, S2, JMP, 0, RD | LDIR | INC);
        add(1, S3, JMP, 0, 0);
        add(1, S4, JMP, 0, INC);
        add(1, S5, JMP, 0, LDPC);
        add(0, S6, JMP, 0, 0);
        add(1, IDLE, JMP, 0, 0);
        add(1, S1, JMP, 0, RD | LDIR);
        add(1, S2, JMP, 0, RD | LDIR | INC);
        add(1, S3, JMP, 0, 0);
        add(1, S4, JMP, 0, INC);
        add(1, S5, JMP, 0, LDPC);
        add(1, S6, JMP, 0, LDPC | INC);
        add(1, S7, JMP, 0, 0);
        add(1, S8, JMP, 0, 0);
        // HLT: halt after S4, everything else silent until reset.
        add(1, S1, HLT, 0, RD | LDIR);
        add(1, S2, HLT, 0, RD | LDIR | INC);
        add(1, S3, HLT, 0, 0);
        add(1, S4, HLT, 0, HALT);
        add(1, S5, JMP, 0, HALT);
        add(1, S6, JMP, 0, HALT);
        add(1, S7, ADD, 0, HALT);
        add(1, S8, SKZ, 1, HALT);
        add(1, S1, ADD, 0, HALT);
        add(1, S2, ADD, 0, HALT);
        add(0, IDLE, ADD, 0, 0);
        add(1, IDLE, ADD, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; state = vecs[i].state; fetch = vecs[i].fetch;
            alu_en = vecs[i].alu_en; opcode = vecs[i].opcode; zero = vecs[i].zero;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d st=%02h op=%0d", i, vecs[i].state, vecs[i].opcode),
                {outs(), phase_err}, {vecs[i].exp, 1'b0});
        end

        // Skipped phase S1 -> S3; error is sticky and does not suppress strobes.
        step(0, IDLE, 0, 0, ADD);
        step(1, IDLE, 0, 0, ADD);
        step(1, S1, 1, 0, ADD);
        chk("skip_pre", {outs(), phase_err}, {RD | LDIR, 1'b0});
        step(1, S3, 1, 0, ADD);
        chk("skip_err", {outs(), phase_err}, {8'h00, PC_EN});
        step(1, S4, 1, 0, ADD);
        chk("skip_sticky", {outs(), phase_err}, {INC, PC_EN});
        step(1, S5, 0, 0, ADD);
        chk("skip_sticky2", {outs(), phase_err}, {RD, PC_EN});

        // Non-one-hot phase.
        step(0, IDLE, 0, 0, ADD);
        chk("reset_clears_err", {outs(), phase_err}, {8'h00, 1'b0});
        step(1, IDLE, 0, 0, ADD);
        step(1, S1, 1, 0, ADD);
        step(1, S2, 1, 0, ADD);
        chk("oh_pre", {outs(), phase_err}, {RD | LDIR | INC, 1'b0});
        step(1, 8'h03, 1, 0, ADD);
        chk("not_onehot", {outs(), phase_err}, {8'h00, PC_EN});

        // fetch low during S2 is gated and, with the checker, flagged.
        step(0, IDLE, 0, 0, ADD);
        step(1, IDLE, 0, 0, ADD);
        step(1, S1, 1, 0, ADD);
        step(1, S2, 0, 0, ADD);
        chk("fetch_bad", {outs(), phase_err}, {8'h00, PC_EN});

        // alu_en outside S7.
        step(0, IDLE, 0, 0, ADD);
        step(1, IDLE, 0, 0, ADD);
        step(1, S1, 1, 1, ADD);
        chk("alu_en_bad", {outs(), phase_err}, {RD | LDIR, PC_EN});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
